// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: one synchronous write port and NUM_RD registered read ports.
// A hard-wired zero register is included. Define REGFILE_WR_BYPASS_EN for write-before-read on same-cycle collisions.
module regfile_mp #(
  parameter  int WIDTH    = 64,
  parameter  int DEPTH    = 32,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 31,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_valid
);

  logic [WIDTH-1:0]             mem [DEPTH];
  logic                         wr_ok;
  logic [NUM_RD-1:0][WIDTH-1:0] rd_word;

  assign wr_ok = wr_en && (int'(wr_addr) < DEPTH) && (int'(wr_addr) != ZERO_REG);

  // Out-of-range and zero-register reads resolve to 0 before the array lookup is used
  always_comb begin
    rd_word = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if ((int'(rd_addr[p]) < DEPTH) && (int'(rd_addr[p]) != ZERO_REG)) begin
        rd_word[p] = mem[rd_addr[p]];
      end
`ifdef REGFILE_WR_BYPASS_EN
      if (wr_ok && (rd_addr[p] == wr_addr)) begin
        rd_word[p] = wr_data;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
      rd_valid <= rd_en;
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          rd_data[p] <= rd_word[p];
        end
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the fixed 32x64 combinational read mux.
- Holds DEPTH registers of WIDTH bits with one synchronous write port and NUM_RD registered read ports.
- A hard-wired zero register always reads 0.
- Sits between decode and execute in the CPU datapath; replaces the current register file plus read-mux pair.

Parameters:
- WIDTH, 64, bits per register.
- DEPTH, 32, number of architectural registers (2..64).
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 31, index that always reads 0 and ignores writes; a value >= DEPTH disables the zero register.
- AW, $clog2(DEPTH), localparam address width (derived, not overridable).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe.
- wr_addr  input  AW  write register index.
- wr_data  input  WIDTH  write data.
- rd_en  input  NUM_RD  per-port read request.
- rd_addr  input  NUM_RD x AW  per-port read index (packed array, port 0 in LSBs).
- rd_data  output  NUM_RD x WIDTH  per-port registered read data.
- rd_valid  output  NUM_RD  per-port data-valid, one cycle after the accepted request.

Behaviour:
- Reset is sampled on posedge clk only.
- While reset=1: all DEPTH registers clear to 0; rd_data clears to 0; rd_valid clears to 0.
- Any wr_en or rd_en in a reset cycle is dropped.
- Write: at posedge with wr_en=1, reset=0, wr_addr != ZERO_REG and wr_addr < DEPTH, mem[wr_addr] <= wr_data.
  - Otherwise no state changes.
  - Writes to ZERO_REG or to an out-of-range index are silently ignored.
- Read, port p: at posedge with rd_en[p]=1, rd_data[p] <= mem[rd_addr[p]] and rd_valid[p] <= 1.
  - Latency is exactly 1 cycle.
  - Reads of ZERO_REG or out-of-range indices return 0 with rd_valid[p]=1.
- Port p with rd_en[p]=0 clears rd_valid[p] to 0. rd_data[p] holds its previous value; the consumer ignores it.
- Ports are fully independent:
  - Any ports may read the same index in the same cycle.
  - No arbitration and no stall; all requests are accepted every cycle.
- Read and write to the same index in the same cycle: the result is governed by WR_BYPASS_EN (see Optional Feature).
- Back-to-back: a write at cycle N followed by a read of the same index requested at cycle N+1 returns the new data at N+2, regardless of the macro.
- Reset deasserting: the first request is accepted at the first posedge with reset=0.
- Reset asserting mid-stream: any in-flight rd_valid drops to 0 at that posedge.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined: a same-cycle read of an index being written (wr_en=1, same valid non-zero index) captures wr_data into rd_data, i.e. write-before-read. The zero register still returns 0.
- Undefined: a same-cycle read captures the pre-write mem contents (read-before-write). The new value is visible to requests from the next cycle.
- All other behaviour is identical with and without the macro.

Test Plan:
1. Reset then read all: assert reset 2 cycles, then read indices 0..31 on both ports -> every rd_data=0, rd_valid=1 exactly one cycle after each request.
2. Fill and readback: write mem[i]=64'hA5A5_0000_0000_0000+i for i=0..31, then read i on port 0 and 31-i on port 1.
   - Expect port 0 = A5A5_..._i for i<31 and 0 for i=31.
   - Expect port 1 mirrored likewise.
3. Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to index 31, then read 31 -> rd_data=0. A neighbouring read of index 30 is unaffected.
4. Same-cycle collision: mem[5]=64'h1111; in one cycle write 64'h2222 to 5 and read 5 on both ports.
   - Bypass defined -> both ports 64'h2222.
   - Bypass undefined -> both 64'h1111, and a read on the next cycle -> 64'h2222.
5. Reset mid-operation: with rd_en=2'b11 active and mem[3]=64'h77, assert reset for one cycle.
   - rd_valid=0 the following cycle.
   - A subsequent read of 3 returns 0.
6. Parametric build: WIDTH=32, DEPTH=24, NUM_RD=3, ZERO_REG=0.
   - A write to 25 is ignored and a read of 25 returns 0.
   - A write of 32'hDEAD_BEEF to 23, read on all 3 ports -> 32'hDEADBEEF on all three.
   - A read of index 0 returns 0.
